// File: rtl/line_feed_ctrl_if.sv
// Pixel-stream bundle between line_feed_ctrl, its FWFT pixel source and the
// image-processing pipeline.
//   i_src_valid / i_src_data / o_src_rd : first-word-fall-through source side
//   i_intr                              : pipeline line-consumed interrupt
//   o_data_valid / o_data               : registered pixel stream to pipeline
// master: the line sequencer; slave: whatever sits on the other side
// (source, pipeline, or a testbench standing in for both).
interface line_feed_ctrl_if;
  logic       i_src_valid;
  logic [7:0] i_src_data;
  logic       o_src_rd;
  logic       i_intr;
  logic       o_data_valid;
  logic [7:0] o_data;

  modport master (
    input  i_src_valid, i_src_data, i_intr,
    output o_src_rd, o_data_valid, o_data
  );

  modport slave (
    output i_src_valid, i_src_data, i_intr,
    input  o_src_rd, o_data_valid, o_data
  );
endinterface

// File: rtl/line_feed_ctrl.sv
// Line sequencer feeding an 8-bit grayscale frame into the image pipeline.
// Primes the pipeline with PRIME_LINES rows, then releases one row per
// line-consumed interrupt credit, then appends PAD_LINES zero rows (each also
// gated by a credit) so the last output rows drain.
// Ports:
//   axi_clk, axi_reset : clock, asynchronous active-high reset
//   i_start            : frame start pulse (honoured only when idle)
//   bus                : pixel source / pipeline bundle (master side)
//   o_busy             : high whenever a frame is in progress
//   o_done             : single-cycle frame-complete pulse
//   o_line_cnt         : rows fully emitted in the current frame
module line_feed_ctrl #(
  parameter  int IMG_WIDTH   = 512,
  parameter  int IMG_HEIGHT  = 512,
  parameter  int PRIME_LINES = 4,
  parameter  int PAD_LINES   = 2,
  localparam int LINE_W      = $clog2(IMG_HEIGHT + PAD_LINES + 1)
) (
  input  logic              axi_clk,
  input  logic              axi_reset,
  input  logic              i_start,
  line_feed_ctrl_if.master  bus,
  output logic              o_busy,
  output logic              o_done,
  output logic [LINE_W-1:0] o_line_cnt
);

  localparam int PIX_W = $clog2(IMG_WIDTH);

  localparam logic [PIX_W-1:0]  LAST_PIX  = PIX_W'(IMG_WIDTH - 1);
  localparam logic [LINE_W-1:0] PRIME_CNT = LINE_W'(PRIME_LINES);
  localparam logic [LINE_W-1:0] IMG_CNT   = LINE_W'(IMG_HEIGHT);
  localparam logic [LINE_W-1:0] TOTAL_CNT = LINE_W'(IMG_HEIGHT + PAD_LINES);

  typedef enum logic [2:0] {
    IDLE, PRIME, WAIT_REQ, LINE, PAD_WAIT, PAD, DONE
  } state_t;

  state_t             state, stateNext;
  logic [PIX_W-1:0]   pixCnt;
  logic [LINE_W-1:0]  lineCnt;
  logic [LINE_W-1:0]  lineNext;
  logic [1:0]         credit;
  logic               intrPrev;
  logic               edgeReg;
  logic               dataValid;
  logic [7:0]         dataReg;

  logic pop, padEmit, emit, lastPix, rowDone;
  logic hasCredit, consume, creditInc;

  always_comb begin
    pop       = ((state == PRIME) || (state == LINE)) && bus.i_src_valid;
    padEmit   = (state == PAD);
    emit      = pop || padEmit;
    lastPix   = (pixCnt == LAST_PIX);
    rowDone   = emit && lastPix;
    lineNext  = lineCnt + LINE_W'(1);
    hasCredit = (credit != 2'd0);
    consume   = ((state == WAIT_REQ) || (state == PAD_WAIT)) && hasCredit;
    // Edges arriving while idle or finishing are dropped.
    creditInc = edgeReg && (state != IDLE) && (state != DONE);
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:     if (i_start) stateNext = PRIME;
      PRIME, LINE: begin
        if (rowDone) begin
          if (lineNext == IMG_CNT)
            stateNext = (PAD_LINES == 0) ? DONE : PAD_WAIT;
          else if ((state == LINE) || (lineNext == PRIME_CNT))
            stateNext = WAIT_REQ;
        end
      end
      WAIT_REQ: if (hasCredit) stateNext = LINE;
      PAD_WAIT: if (hasCredit) stateNext = PAD;
      PAD:      if (lastPix) stateNext = (lineNext == TOTAL_CNT) ? DONE : PAD_WAIT;
      DONE:     stateNext = IDLE;
      default:  stateNext = IDLE;
    endcase
  end

  always_ff @(posedge axi_clk or posedge axi_reset) begin
    if (axi_reset) state <= IDLE;
    else           state <= stateNext;
  end

  always_ff @(posedge axi_clk or posedge axi_reset) begin
    if (axi_reset) begin
      pixCnt  <= '0;
      lineCnt <= '0;
    end else if ((state == IDLE) && i_start) begin
      pixCnt  <= '0;
      lineCnt <= '0;
    end else if (emit) begin
      if (lastPix) begin
        pixCnt  <= '0;
        lineCnt <= lineNext;
      end else begin
        pixCnt  <= pixCnt + PIX_W'(1);
      end
    end
  end

  // Interrupt sampled once, edge registered, then credited: an edge on the
  // raw input shows up in the credit count two cycles later.
  always_ff @(posedge axi_clk or posedge axi_reset) begin
    if (axi_reset) begin
      intrPrev <= 1'b0;
      edgeReg  <= 1'b0;
    end else begin
      intrPrev <= bus.i_intr;
      edgeReg  <= bus.i_intr && !intrPrev;
    end
  end

  // Simultaneous edge and consume cancel, even when saturated.
  always_ff @(posedge axi_clk or posedge axi_reset) begin
    if (axi_reset)
      credit <= '0;
    else if (state == IDLE)
      credit <= '0;
    else if (consume && !creditInc)
      credit <= credit - 2'd1;
    else if (!consume && creditInc && (credit != 2'b11))
      credit <= credit + 2'd1;
  end

  always_ff @(posedge axi_clk or posedge axi_reset) begin
    if (axi_reset) begin
      dataValid <= 1'b0;
      dataReg   <= '0;
    end else begin
      dataValid <= emit;
      if (pop)          dataReg <= bus.i_src_data;
      else if (padEmit) dataReg <= '0;
    end
  end

  assign bus.o_src_rd     = pop;
  assign bus.o_data_valid = dataValid;
  assign bus.o_data       = dataReg;
  assign o_busy           = (state != IDLE);
  assign o_done           = (state == DONE);
  assign o_line_cnt       = lineCnt;

endmodule
